touch_key_decoder: RTL

//   Front end for the touch pad. Synchronises and debounces the raw touch_key line,

---
 rtl/touch_key_decoder_pkg.sv | 27 ++
 rtl/touch_key_decoder_if.sv | 34 +++
 rtl/touch_key_decoder_key_debounce.sv | 59 +++++
 rtl/touch_key_decoder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/touch_key_decoder_pkg.sv
// Shared types and default timing for the touch key front end.
// Holds the classifier state encoding and small elaboration-time helpers.
package touch_key_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  // Defaults assume a 50 MHz system clock.
  localparam logic DEF_KEY_ACTIVE     = 1'b1;
  localparam int   DEF_DEBOUNCE_CYC   = 1_000_000;
  localparam int   DEF_LONG_CYC       = 50_000_000;
  localparam int   DEF_DOUBLE_GAP_CYC = 15_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/touch_key_decoder_if.sv
// Pad input and gesture event outputs of the touch key decoder.
// The decoder side uses master; LED/mode controllers use slave.
interface touch_key_decoder_if;
  logic touch_key;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic holding;

  modport master (
    input  touch_key,
    output key_level,
    output press_pulse,
    output release_pulse,
    output short_pulse,
    output long_pulse,
    output double_pulse,
    output holding
  );

  modport slave (
    output touch_key,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  short_pulse,
    input  long_pulse,
    input  double_pulse,
    input  holding
  );
endinterface

// File: rtl/touch_key_decoder_key_debounce.sv
// Synchronises the raw pad level, normalises polarity and debounces it.
// Exposes next-cycle edge strobes so the classifier can update alongside the pulses.
module touch_key_decoder_key_debounce
  import touch_key_decoder_pkg::*;
#(
  parameter logic KEY_ACTIVE   = DEF_KEY_ACTIVE,
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic touch_key,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_evt,
  output logic release_evt
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sample;
  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // A constant XOR, so the synchroniser still sees a single raw path.
  assign sample = touch_key ^ ~KEY_ACTIVE;

  assign flip        = (sync_p1 != key_level) && (cnt == CNT_LAST);
  assign press_evt   = flip & sync_p1;
  assign release_evt = flip & ~sync_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_p0       <= 1'b0;
      sync_p1       <= 1'b0;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_p0       <= sample;
      sync_p1       <= sync_p0;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (sync_p1 == key_level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt       <= '0;
        key_level <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/touch_key_decoder.sv
// Touch pad front end: debounced level plus press/release/short/long/double pulses.
// The classifier FSM runs on the debounced edges and owns the gesture timer.
module touch_key_decoder
  import touch_key_decoder_pkg::*;
#(
  parameter logic KEY_ACTIVE     = DEF_KEY_ACTIVE,
  parameter int   DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
  parameter int   LONG_CYC       = DEF_LONG_CYC,
  parameter int   DOUBLE_GAP_CYC = DEF_DOUBLE_GAP_CYC
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  touch_key_decoder_if.master   bus
);

  localparam int                 TIMER_W   = cnt_width(max_int(LONG_CYC, DOUBLE_GAP_CYC));
  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(DOUBLE_GAP_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  logic               key_level;
  logic               press_pulse;
  logic               release_pulse;
  logic               press_evt;
  logic               release_evt;
  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               short_pulse;
  logic               long_pulse;
  logic               double_pulse;
  logic               holding;

  touch_key_decoder_key_debounce #(
    .KEY_ACTIVE   (KEY_ACTIVE),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .touch_key     (bus.touch_key),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_evt     (press_evt),
    .release_evt   (release_evt)
  );

  // Edges are tested before timeouts so an edge always wins a same-cycle tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      holding      <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      if (timer != TIMER_MAX) begin
        timer <= timer + TIMER_W'(1);
      end
      case (state)
        IDLE: begin
          timer <= '0;
          if (press_evt) begin
            state <= PRESS1;
          end
        end
        PRESS1: begin
          if (release_evt) begin
            state <= GAP;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            long_pulse <= 1'b1;
            holding    <= 1'b1;
            state      <= LONG_HOLD;
            timer      <= '0;
          end
        end
        LONG_HOLD: begin
          timer <= '0;
          if (release_evt) begin
            holding <= 1'b0;
            state   <= IDLE;
          end
        end
        GAP: begin
          if (press_evt) begin
            state <= PRESS2;
            timer <= '0;
          end else if (timer == GAP_LAST) begin
            short_pulse <= 1'b1;
            state       <= IDLE;
            timer       <= '0;
          end
        end
        PRESS2: begin
          if (release_evt) begin
            double_pulse <= 1'b1;
            state        <= IDLE;
            timer        <= '0;
          end else if (timer == LONG_LAST) begin
            double_pulse <= 1'b1;
            holding      <= 1'b1;
            state        <= LONG_HOLD;
            timer        <= '0;
          end
        end
        default: begin
          holding <= 1'b0;
          state   <= IDLE;
          timer   <= '0;
        end
      endcase
    end
  end

  assign bus.key_level     = key_level;
  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.short_pulse   = short_pulse;
  assign bus.long_pulse    = long_pulse;
  assign bus.double_pulse  = double_pulse;
  assign bus.holding       = holding;

endmodule
